// File: rtl/branch_resolve_unit_pkg.sv
// Shared core definitions for jump/branch resolution:
// opcode values and the registered result record.
package branch_resolve_unit_pkg;

  localparam int unsigned OP_JAL  = 24;
  localparam int unsigned OP_JALR = 25;
  localparam int unsigned OP_BEQ  = 26;
  localparam int unsigned OP_BNE  = 27;
  localparam int unsigned OP_BLT  = 28;
  localparam int unsigned OP_BGE  = 29;
  localparam int unsigned OP_BLTU = 30;
  localparam int unsigned OP_BGEU = 31;

  typedef struct packed {
    logic       jb_enable;
    logic       mispredict;
    logic       misalign_exc;
    logic       write_req;
    logic [4:0] write_addr;
  } jb_result_t;

endpackage

// File: rtl/branch_resolve_unit_compare.sv
// Operand comparator for conditional branches:
// equality, signed less-than and unsigned less-than.
module branch_compare #(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            eq,
  output logic            lt,
  output logic            ltu
);

  assign eq  = (a == b);
  assign lt  = ($signed(a) < $signed(b));
  assign ltu = (a < b);

endmodule

// File: rtl/branch_resolve_unit.sv
// Resolves JAL/JALR/branches into a registered redirect,
// link write-back and misprediction statistics.
module branch_resolve_unit
  import branch_resolve_unit_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int OP_W  = 6,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [XLEN-1:0]  pc,
  input  logic [XLEN-1:0]  src1_value,
  input  logic [XLEN-1:0]  src2_value,
  input  logic [XLEN-1:0]  imm,
  input  logic [4:0]       rd,
  input  logic [OP_W-1:0]  operation_con,
  input  logic             pred_taken,
  input  logic [XLEN-1:0]  pred_target,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             jb_enable,
  output logic [XLEN-1:0]  jb_target_pc,
  output logic             mispredict,
  output logic             misalign_exc,
  output logic             write_req,
  output logic [4:0]       write_addr,
  output logic [XLEN-1:0]  write_data,
  output logic [CNT_W-1:0] branch_cnt,
  output logic [CNT_W-1:0] mispred_cnt
);

  logic eq, lt, ltu;

  branch_compare #(.XLEN(XLEN)) u_cmp (
    .a   (src1_value),
    .b   (src2_value),
    .eq  (eq),
    .lt  (lt),
    .ltu (ltu)
  );

  logic op_jal, op_jalr, op_beq, op_bne;
  logic op_blt, op_bge, op_bltu, op_bgeu;

  assign op_jal  = operation_con == OP_W'(OP_JAL);
  assign op_jalr = operation_con == OP_W'(OP_JALR);
  assign op_beq  = operation_con == OP_W'(OP_BEQ);
  assign op_bne  = operation_con == OP_W'(OP_BNE);
  assign op_blt  = operation_con == OP_W'(OP_BLT);
  assign op_bge  = operation_con == OP_W'(OP_BGE);
  assign op_bltu = operation_con == OP_W'(OP_BLTU);
  assign op_bgeu = operation_con == OP_W'(OP_BGEU);

  logic            is_jb;
  logic            taken;
  logic [XLEN-1:0] sum;
  logic [XLEN-1:0] target;
  logic [XLEN-1:0] seq_pc;
  logic            mp_raw;
  jb_result_t      nxt;

  always_comb begin
    is_jb = 1'b1;
    taken = 1'b0;
    unique case (1'b1)
      op_jal:  taken = 1'b1;
      op_jalr: taken = 1'b1;
      op_beq:  taken = eq;
      op_bne:  taken = !eq;
      op_blt:  taken = lt;
      op_bge:  taken = !lt;
      op_bltu: taken = ltu;
      op_bgeu: taken = !ltu;
      default: is_jb = 1'b0;
    endcase
  end

  always_comb begin
    sum    = (op_jalr ? src1_value : pc) + imm;
    target = op_jalr ? {sum[XLEN-1:1], 1'b0} : sum;
    seq_pc = pc + XLEN'(4);
    mp_raw = (taken != pred_taken)
           || (taken && (target != pred_target));
    nxt              = '0;
    nxt.misalign_exc = taken && (target[1:0] != 2'b00);
    nxt.mispredict   = mp_raw && !nxt.misalign_exc;
    nxt.jb_enable    = nxt.mispredict;
    nxt.write_req    = (op_jal || op_jalr)
                     && (rd != 5'd0)
                     && !nxt.misalign_exc;
    nxt.write_addr   = rd;
  end

  jb_result_t      res_q;
  logic [XLEN-1:0] target_q;
  logic [XLEN-1:0] link_q;
  logic            valid_q;
  logic            fire;
  logic            consume;

  assign in_ready = !valid_q || out_ready;
  assign fire     = in_valid && in_ready;
  assign consume  = valid_q && out_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q     <= 1'b0;
      res_q       <= '0;
      target_q    <= '0;
      link_q      <= '0;
      branch_cnt  <= '0;
      mispred_cnt <= '0;
    end else if (flush) begin
      valid_q <= 1'b0;
    end else begin
      if (consume) begin
        if (branch_cnt != '1)
          branch_cnt <= branch_cnt + CNT_W'(1);
        if (res_q.mispredict && mispred_cnt != '1)
          mispred_cnt <= mispred_cnt + CNT_W'(1);
      end
      if (fire) begin
        valid_q <= is_jb;
        if (is_jb) begin
          res_q    <= nxt;
          target_q <= taken ? target : seq_pc;
          link_q   <= seq_pc;
        end
      end else if (out_ready) begin
        valid_q <= 1'b0;
      end
    end
  end

  assign out_valid    = valid_q;
  assign jb_enable    = res_q.jb_enable;
  assign mispredict   = res_q.mispredict;
  assign misalign_exc = res_q.misalign_exc;
  assign write_req    = res_q.write_req;
  assign write_addr   = res_q.write_addr;
  assign jb_target_pc = target_q;
  assign write_data   = link_q;

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Self-checking bench: spec-level model plus directed
// literal checks on branch_resolve_unit.
module tb_branch_resolve_unit;

  logic        clk = 1'b0;
  logic        reset, flush, in_valid, in_ready;
  logic [31:0] pc, src1_value, src2_value, imm;
  logic [4:0]  rd;
  logic [5:0]  operation_con;
  logic        pred_taken;
  logic [31:0] pred_target;
  logic        out_valid, out_ready;
  logic        jb_enable, mispredict, misalign_exc, write_req;
  logic [31:0] jb_target_pc, write_data;
  logic [4:0]  write_addr;
  logic [1:0]  branch_cnt, mispred_cnt;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  branch_resolve_unit #(.XLEN(32), .OP_W(6), .CNT_W(2)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .pc(pc), .src1_value(src1_value),
    .src2_value(src2_value), .imm(imm), .rd(rd),
    .operation_con(operation_con),
    .pred_taken(pred_taken), .pred_target(pred_target),
    .out_valid(out_valid), .out_ready(out_ready),
    .jb_enable(jb_enable), .jb_target_pc(jb_target_pc),
    .mispredict(mispredict), .misalign_exc(misalign_exc),
    .write_req(write_req), .write_addr(write_addr),
    .write_data(write_data),
    .branch_cnt(branch_cnt), .mispred_cnt(mispred_cnt)
  );

  typedef struct {
    logic [31:0] tgt;
    logic        mis;
    logic        mp;
    logic        wr;
    logic [4:0]  wa;
    logic [31:0] wd;
  } exp_t;

  function automatic bit is_jb(input logic [5:0] op);
    return op >= 6'd24 && op <= 6'd31;
  endfunction

  function automatic exp_t predict(
    input logic [5:0] op, input logic [31:0] p,
    input logic [31:0] a, input logic [31:0] b,
    input logic [31:0] im, input logic [4:0] r,
    input logic pt, input logic [31:0] ptg);
    exp_t e;
    bit tk;
    logic [31:0] t;
    t = p + im;
    case (op)
      6'd24: tk = 1;
      6'd25: begin tk = 1; t = (a + im) & ~32'd1; end
      6'd26: tk = (a == b);
      6'd27: tk = (a != b);
      6'd28: tk = ($signed(a) < $signed(b));
      6'd29: tk = ($signed(a) >= $signed(b));
      6'd30: tk = (a < b);
      default: tk = (a >= b);
    endcase
    e.mis = tk && (t % 4 != 0);
    e.tgt = tk ? t : p + 32'd4;
    e.mp  = !e.mis && ((tk != pt) || (tk && t != ptg));
    e.wr  = !e.mis && (op == 6'd24 || op == 6'd25) && r != 0;
    e.wa  = r;
    e.wd  = p + 32'd4;
    return e;
  endfunction

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, want %0h", nm, act, exp);
    end
  endtask

  // model state
  bit   mv = 0;
  exp_t mres;
  int   mbc = 0, mmc = 0;

  always @(posedge clk) begin
    bit acc;
    if (reset) begin
      mv = 0; mbc = 0; mmc = 0;
    end else if (flush) begin
      mv = 0;
    end else begin
      acc = in_valid && (!mv || out_ready);
      if (mv && out_ready) begin
        if (mbc < 3) mbc++;
        if (mres.mp && mmc < 3) mmc++;
      end
      if (acc && is_jb(operation_con)) begin
        mv = 1;
        mres = predict(operation_con, pc, src1_value,
          src2_value, imm, rd, pred_taken, pred_target);
      end else if (acc || out_ready) begin
        mv = 0;
      end
    end
  end

  always @(negedge clk) begin
    if (!reset) begin
      chk("m_in_ready", 64'(in_ready), 64'(!mv || out_ready));
      chk("m_out_valid", 64'(out_valid), 64'(mv));
      if (mv) begin
        chk("m_target", 64'(jb_target_pc), 64'(mres.tgt));
        chk("m_jb_enable", 64'(jb_enable), 64'(mres.mp));
        chk("m_mispredict", 64'(mispredict), 64'(mres.mp));
        chk("m_misalign", 64'(misalign_exc), 64'(mres.mis));
        chk("m_write_req", 64'(write_req), 64'(mres.wr));
        if (mres.wr) begin
          chk("m_write_addr", 64'(write_addr), 64'(mres.wa));
          chk("m_write_data", 64'(write_data), 64'(mres.wd));
        end
      end
      chk("m_branch_cnt", 64'(branch_cnt), 64'(mbc));
      chk("m_mispred_cnt", 64'(mispred_cnt), 64'(mmc));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [5:0] op,
    input logic [31:0] p, input logic [31:0] a,
    input logic [31:0] b, input logic [31:0] im,
    input logic [4:0] r, input logic pt,
    input logic [31:0] ptg);
    in_valid = 1; operation_con = op; pc = p;
    src1_value = a; src2_value = b; imm = im;
    rd = r; pred_taken = pt; pred_target = ptg;
  endtask

  task automatic send(input logic [5:0] op,
    input logic [31:0] p, input logic [31:0] a,
    input logic [31:0] b, input logic [31:0] im,
    input logic [4:0] r, input logic pt,
    input logic [31:0] ptg);
    drive(op, p, a, b, im, r, pt, ptg);
    step();
    in_valid = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1; flush = 0; in_valid = 0; out_ready = 1;
    pc = 0; src1_value = 0; src2_value = 0; imm = 0;
    rd = 0; operation_con = 0; pred_taken = 0;
    pred_target = 0;
    step(); step();
    @(negedge clk);
    chk("rst_out_valid", 64'(out_valid), 0);
    chk("rst_flags", 64'({jb_enable, mispredict,
        misalign_exc, write_req}), 0);
    chk("rst_target", 64'(jb_target_pc), 0);
    chk("rst_wb", 64'({write_addr, write_data}), 0);
    chk("rst_cnts", 64'({branch_cnt, mispred_cnt}), 0);
    step();
    reset = 0;
    @(negedge clk);
    chk("rst_in_ready", 64'(in_ready), 1);
    step();

    // BEQ to a misaligned target
    send(26, 'h100, 100, 100, 10, 0, 0, 0);
    @(negedge clk);
    chk("beq_misalign", 64'(misalign_exc), 1);
    chk("beq_jb_enable", 64'(jb_enable), 0);
    chk("beq_target", 64'(jb_target_pc), 'h10A);
    step();

    // correctly predicted JAL with link
    send(24, 'h100, 0, 0, 'h20, 5, 1, 'h120);
    @(negedge clk);
    chk("jal_jb_enable", 64'(jb_enable), 0);
    chk("jal_write_req", 64'(write_req), 1);
    chk("jal_write_addr", 64'(write_addr), 5);
    chk("jal_write_data", 64'(write_data), 'h104);
    step();

    send(28, 'h200, 32'hFFFF_FFFF, 1, 'h40, 0, 0, 0);
    @(negedge clk);
    chk("blt_target", 64'(jb_target_pc), 'h240);
    chk("blt_mispredict", 64'(mispredict), 1);
    step();
    send(30, 'h200, 32'hFFFF_FFFF, 1, 'h40, 0, 0, 0);
    @(negedge clk);
    chk("bltu_target", 64'(jb_target_pc), 'h204);
    chk("bltu_jb_enable", 64'(jb_enable), 0);
    step();

    send(3, 'h200, 1, 2, 'h40, 7, 0, 0);
    @(negedge clk);
    chk("nonjb_out_valid", 64'(out_valid), 0);
    step();

    reset = 1; step(); reset = 0;
    send(25, 'h0, 'h201, 0, 'h10, 0, 0, 0);
    @(negedge clk);
    chk("jalr_target", 64'(jb_target_pc), 'h210);
    chk("jalr_jb_enable", 64'(jb_enable), 1);
    chk("jalr_cnt_before", 64'(mispred_cnt), 0);
    step();
    @(negedge clk);
    chk("jalr_cnt_after", 64'(mispred_cnt), 1);
    chk("jalr_branch_cnt", 64'(branch_cnt), 1);
    step();

    // back-pressure: A held, B waits
    out_ready = 0;
    drive(26, 'h300, 1, 1, 'h20, 0, 1, 'h320);
    step();
    drive(27, 'h400, 1, 1, 'h8, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("bp_in_ready", 64'(in_ready), 0);
      chk("bp_hold_target", 64'(jb_target_pc), 'h320);
      step();
    end
    out_ready = 1;
    step();
    in_valid = 0;
    @(negedge clk);
    chk("bp_b_valid", 64'(out_valid), 1);
    chk("bp_b_target", 64'(jb_target_pc), 'h404);
    step();

    // flush beats a same-cycle consume
    reset = 1; step(); reset = 0;
    send(27, 'h100, 1, 2, 'h8, 0, 0, 0);
    flush = 1;
    drive(24, 'h500, 0, 0, 'h10, 3, 0, 0);
    step();
    flush = 0; in_valid = 0;
    @(negedge clk);
    chk("flush_out_valid", 64'(out_valid), 0);
    chk("flush_cnts", 64'({branch_cnt, mispred_cnt}), 0);
    step();

    drive(27, 'h100, 1, 2, 'h8, 0, 0, 0);
    for (int i = 0; i < 5; i++) step();
    in_valid = 0;
    step(); step();
    @(negedge clk);
    chk("sat_mispred_cnt", 64'(mispred_cnt), 3);
    chk("sat_branch_cnt", 64'(branch_cnt), 3);
    step();

    // reset while a result is held
    out_ready = 0;
    send(24, 'h600, 0, 0, 'h40, 9, 0, 0);
    reset = 1; step(); reset = 0;
    @(negedge clk);
    chk("midrst_out_valid", 64'(out_valid), 0);
    chk("midrst_in_ready", 64'(in_ready), 1);
    step();

    for (int i = 0; i < 60; i++) begin
      logic [5:0] op;
      op = 6'(22 + (i % 11));
      drive(op, 32'h1000 + 32'(4 * i),
            32'(i - 5), 32'($urandom_range(0, 3)) - 32'd1,
            32'(4 * ($urandom_range(0, 8))) - 32'd16,
            5'($urandom_range(0, 2)),
            1'($urandom_range(0, 1)),
            32'h1000 + 32'(4 * i));
      in_valid = 1'($urandom_range(0, 3) != 0);
      out_ready = 1'($urandom_range(0, 2) != 0);
      flush = ($urandom_range(0, 19) == 0);
      step();
    end
    in_valid = 0; flush = 0; out_ready = 1;
    step(); step(); step();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
